mmio_timer_periph: RTL and testbench
====================================

// Module: mmio_timer_periph
// PURPOSE
//  Memory-mapped peripheral responder on the CPU data bus (mem_rd/mem_wr side of the datapath).
//  Provides a reload timer that raises the level irq consumed by the control unit.
//  Also provides LED, switch, 7-seg and free-running systick registers.
//  It sits beside data RAM; the top-level read mux selects rdata when hit=1.
// PARAMETERS
//  BASE      32'h4000_0000  peripheral window base; window = BASE..BASE+0x1C
//  PRESCALE  1              timer ticks once per PRESCALE clk cycles (>=1)
// PORTS
//  clk      in   1   system clock; all state updates on posedge
//  reset    in   1   synchronous, active-high
//  addr     in   32  byte address from ALU result
//  wdata    in   32  store data (rt)
//  mem_rd   in   1   load strobe
//  mem_wr   in   1   store strobe
//  rdata    out  32  load data, combinational
//  hit      out  1   addr[31:5]==BASE[31:5] && addr[1:0]==0
//  irq      out  1   interrupt request to ctrl, level = TCON[2]
//  led      out  8   LED register
//  switch   in   8   board switches
//  digi     out  12  7-seg: [11:8] anode select, [7:0] segments
//  systick  out  32  free-running cycle count
// BEHAVIOUR
//  Register map (offset): 00 TH, 04 TL, 08 TCON[2:0], 0C LED[7:0], 10 SWITCH (RO),
//   14 DIGI[11:0], 18 SYSTICK (RO), 1C reserved (reads 0, writes ignored).
//  TCON: bit0 = run, bit1 = irq enable, bit2 = irq status; bits 31:3 read 0.
//  Reset: TH=TL=0, TCON=0, led=0, digi=12'hFFF, systick=0, prescale counter=0.
//   irq=0 the cycle after reset is sampled high.
//  Reads: rdata = selected register when hit && mem_rd, else 32'h0. Zero-latency, no side effects.
//  Writes: when hit && mem_wr, the register is updated at that posedge; RO offsets are ignored.
//  Prescaler: a counter 0..PRESCALE-1 runs while TCON[0]=1 and produces a tick at wrap.
//   It holds its value while TCON[0]=0.
//  Tick:
//   - TL==32'hFFFF_FFFF: TL<=TH; if TCON[1], TCON[2]<=1.
//   - otherwise: TL<=TL+1 (mod 2^32).
//  irq stays high until software clears TCON[2]. The status bit stays set even if TCON[1] is later cleared.
//  Simultaneous events, same cycle:
//   - CPU write to TL vs tick: the write wins.
//   - CPU write to TCON vs an overflow that sets status: written bits [1:0] apply, and bit2 = 1.
//     The set wins, so no interrupt is lost.
//   - Write to TH during overflow: the reload uses the old TH.
//  systick: +1 every clk, wraps mod 2^32, not writable.
//  Reset mid-count: all state returns to reset values on the next edge; a pending irq is dropped.
//  Accesses with addr[1:0]!=0 are not hits: ignored, rdata=0.
// STRUCTURE
//  Shared package/header (periph_defs):
//   - offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI, OFF_SYSTICK
//   - TCON bit indices: TCON_RUN=0, TCON_IE=1, TCON_IRQ=2
//  One sub-module, reload_timer: prescaler, TH/TL/TCON and the overflow/irq logic.
//   It takes write strobes from the address decoder.
//  The top level holds the decode, LED/DIGI/systick registers and the read mux.
// TESTING
//  1. Reset, then read all offsets: TH=TL=TCON=0, LED=0, DIGI=0xFFF, SW = switch pins; irq=0.
//  2. TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3, PRESCALE=1:
//     - irq rises 2 cycles after the TCON write edge;
//     - TL then counts 0xFFFF_FFFC, FD, ...
//     Writing TCON=3 drops irq on the next edge.
//  3. Same setup with TCON=1 (IE=0): TL reloads, TCON[2] stays 0, irq stays 0.
//  4. Overflow in the same cycle as a TCON=3 write: TCON reads 7 and irq=1.
//     Overflow in the same cycle as a TL=5 write: TL reads 5 and no reload happens.
//  5. PRESCALE=4, TCON=1: TL increments once per 4 clks.
//     Clearing TCON[0] freezes both TL and the prescaler.
//  6. Store to BASE+0x20 or BASE+0x05: hit=0, no register changes.
//     Assert reset while irq=1: irq=0 and TL=0 after one edge.

Source files
------------

// File: rtl/mmio_timer_periph_pkg.sv
// Shared definitions for the MMIO timer peripheral: register offsets,
// TCON bit positions and the decoder's write-strobe bundle.
package mmio_timer_periph_pkg;

  // Byte offsets inside the 32-byte peripheral window
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_SW      = 5'h10;
  localparam logic [4:0] OFF_DIGI    = 5'h14;
  localparam logic [4:0] OFF_SYSTICK = 5'h18;

  localparam int TCON_RUN = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;

  localparam logic [11:0] DIGI_RESET = 12'hFFF;

  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
    logic led;
    logic digi;
  } wr_strobe_t;

endpackage

// File: rtl/mmio_timer_periph_if.sv
// CPU data-bus view of the peripheral: address/data/strobes in, load data and hit out.
interface mmio_timer_periph_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output addr, wdata, mem_rd, mem_wr,
    input  rdata, hit
  );

  modport slave (
    input  addr, wdata, mem_rd, mem_wr,
    output rdata, hit
  );
endinterface

// File: rtl/mmio_timer_periph_reload_timer.sv
// Reload timer: prescaler, TH/TL/TCON registers and the overflow/irq logic.
// Software writes arrive as per-register strobes from the address decoder.
module mmio_timer_periph_reload_timer
  import mmio_timer_periph_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   th_q, th_d;
  logic [31:0]   tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic          tick;
  logic          ovf;
  logic          ovf_set;

  // Prescaler freezes in place while the timer is stopped
  always_comb begin
    pcnt_d = pcnt_q;
    tick   = 1'b0;
    if (tcon_q[TCON_RUN]) begin
      if (pcnt_q == PS_LAST) begin
        pcnt_d = '0;
        tick   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // CPU writes take priority over the tick, except the status set which must never be lost
  always_comb begin
    ovf     = tick && (tl_q == 32'hFFFF_FFFF);
    ovf_set = ovf && tcon_q[TCON_IE];

    th_d = wr_th ? wdata : th_q;

    tl_d = tl_q;
    if (tick) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (wr_tl) begin
      tl_d = wdata;
    end

    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d = wdata[2:0];
    end
    if (ovf_set) begin
      tcon_d[TCON_IRQ] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      th_q   <= 32'h0;
      tl_q   <= 32'h0;
      tcon_q <= 3'b000;
    end else begin
      pcnt_q <= pcnt_d;
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = tcon_q[TCON_IRQ];

endmodule

// File: rtl/mmio_timer_periph.sv
// Memory-mapped timer/LED/switch/7-seg/systick responder on the CPU data bus.
// Holds the address decode, the simple output registers and the load-data mux.
module mmio_timer_periph
  import mmio_timer_periph_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h4000_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_timer_periph_if.slave   bus,
  output logic                 irq,
  output logic [7:0]           led,
  input  logic [7:0]           switch,
  output logic [11:0]          digi,
  output logic [31:0]          systick
);

  logic        hit;
  logic        wr_en;
  logic [4:0]  off;
  wr_strobe_t  wr_stb;

  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q, systick_d;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] rdata_sel;

  // Misaligned accesses are deliberately not claimed, so they fall through as misses
  assign hit   = (bus.addr[31:5] == BASE[31:5]) && (bus.addr[1:0] == 2'b00);
  assign off   = bus.addr[4:0];
  assign wr_en = hit && bus.mem_wr;

  always_comb begin
    wr_stb      = '0;
    wr_stb.th   = wr_en && (off == OFF_TH);
    wr_stb.tl   = wr_en && (off == OFF_TL);
    wr_stb.tcon = wr_en && (off == OFF_TCON);
    wr_stb.led  = wr_en && (off == OFF_LED);
    wr_stb.digi = wr_en && (off == OFF_DIGI);
  end

  mmio_timer_periph_reload_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr_stb.th),
    .wr_tl   (wr_stb.tl),
    .wr_tcon (wr_stb.tcon),
    .wdata   (bus.wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  always_comb begin
    led_d     = wr_stb.led  ? bus.wdata[7:0]  : led_q;
    digi_d    = wr_stb.digi ? bus.wdata[11:0] : digi_q;
    systick_d = systick_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= 8'h00;
      digi_q    <= DIGI_RESET;
      systick_q <= 32'h0;
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  // Read-only and reserved offsets return their value (or zero) without side effects
  always_comb begin
    rdata_sel = 32'h0;
    case (off)
      OFF_TH:      rdata_sel = th;
      OFF_TL:      rdata_sel = tl;
      OFF_TCON:    rdata_sel = {29'h0, tcon};
      OFF_LED:     rdata_sel = {24'h0, led_q};
      OFF_SW:      rdata_sel = {24'h0, switch};
      OFF_DIGI:    rdata_sel = {20'h0, digi_q};
      OFF_SYSTICK: rdata_sel = systick_q;
      default:     rdata_sel = 32'h0;
    endcase
  end

  assign bus.rdata = (hit && bus.mem_rd) ? rdata_sel : 32'h0;
  assign bus.hit   = hit;
  assign led       = led_q;
  assign digi      = digi_q;
  assign systick   = systick_q;

endmodule

// File: tb/tb_mmio_timer_periph.sv
// Self-checking bench: two peripherals (PRESCALE 1 and 4) checked every cycle
// against a register-map model, plus directed reads with literal expectations.
module tb_mmio_timer_periph;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sw;
  logic        chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];
  logic        rd_v [2];
  logic        wr_v [2];
  logic [31:0] rdata_v [2];
  logic        hit_v [2];
  logic        irq_v [2];
  logic [7:0]  led_v [2];
  logic [11:0] digi_v [2];
  logic [31:0] systick_v [2];

  // Model state
  logic [31:0] m_th [2];
  logic [31:0] m_tl [2];
  logic [2:0]  m_tcon [2];
  logic [7:0]  m_led [2];
  logic [11:0] m_digi [2];
  logic [31:0] m_sys [2];
  int          m_run [2];

  always #5 clk = ~clk;

  mmio_timer_periph_if b0 ();
  mmio_timer_periph_if b1 ();

  assign b0.addr   = addr_v[0];
  assign b0.wdata  = wdata_v[0];
  assign b0.mem_rd = rd_v[0];
  assign b0.mem_wr = wr_v[0];
  assign rdata_v[0] = b0.rdata;
  assign hit_v[0]   = b0.hit;
  assign b1.addr   = addr_v[1];
  assign b1.wdata  = wdata_v[1];
  assign b1.mem_rd = rd_v[1];
  assign b1.mem_wr = wr_v[1];
  assign rdata_v[1] = b1.rdata;
  assign hit_v[1]   = b1.hit;

  mmio_timer_periph #(.BASE(BASE), .PRESCALE(1)) u0 (
    .clk(clk), .reset(reset), .bus(b0), .irq(irq_v[0]), .led(led_v[0]),
    .switch(sw), .digi(digi_v[0]), .systick(systick_v[0])
  );

  mmio_timer_periph #(.BASE(BASE), .PRESCALE(4)) u1 (
    .clk(clk), .reset(reset), .bus(b1), .irq(irq_v[1]), .led(led_v[1]),
    .switch(sw), .digi(digi_v[1]), .systick(systick_v[1])
  );

  function automatic int ps_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] m_rdata(input int d);
    logic [31:0] r;
    r = 32'h0;
    if (m_hit(addr_v[d]) && rd_v[d]) begin
      case (addr_v[d][4:0])
        5'h00: r = m_th[d];
        5'h04: r = m_tl[d];
        5'h08: r = {29'h0, m_tcon[d]};
        5'h0C: r = {24'h0, m_led[d]};
        5'h10: r = {24'h0, sw};
        5'h14: r = {20'h0, m_digi[d]};
        5'h18: r = m_sys[d];
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  // Register-map model: one update per clock from the bus inputs of that cycle
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit          we, tk, ov, set_irq;
      logic [31:0] nth, ntl;
      logic [2:0]  ntc;
      if (reset) begin
        m_th[d] = 0; m_tl[d] = 0; m_tcon[d] = 0; m_led[d] = 0;
        m_digi[d] = 12'hFFF; m_sys[d] = 0; m_run[d] = 0;
      end else begin
        we = m_hit(addr_v[d]) && wr_v[d];
        tk = m_tcon[d][0] && ((m_run[d] % ps_of(d)) == ps_of(d) - 1);
        if (m_tcon[d][0]) m_run[d] = m_run[d] + 1;
        ov = tk && (m_tl[d] == 32'hFFFF_FFFF);
        set_irq = ov && m_tcon[d][1];
        nth = m_th[d];
        ntl = tk ? (ov ? m_th[d] : m_tl[d] + 1) : m_tl[d];
        ntc = m_tcon[d];
        if (set_irq) ntc[2] = 1'b1;
        if (we) begin
          case (addr_v[d][4:0])
            5'h00: nth = wdata_v[d];
            5'h04: ntl = wdata_v[d];
            5'h08: ntc = {wdata_v[d][2] | set_irq, wdata_v[d][1:0]};
            5'h0C: m_led[d] = wdata_v[d][7:0];
            5'h14: m_digi[d] = wdata_v[d][11:0];
            default: ;
          endcase
        end
        m_th[d] = nth; m_tl[d] = ntl; m_tcon[d] = ntc;
        m_sys[d] = m_sys[d] + 1;
      end
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %h want %h", name, d, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("irq", d, irq_v[d], m_tcon[d][2]);
        chk("led", d, led_v[d], m_led[d]);
        chk("digi", d, digi_v[d], m_digi[d]);
        chk("systick", d, systick_v[d], m_sys[d]);
        chk("hit", d, hit_v[d], m_hit(addr_v[d]));
        chk("rdata", d, rdata_v[d], m_rdata(d));
      end
    end
  end

  task automatic cyc(input int d, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      addr_v[e] = 32'h0; wdata_v[e] = 32'h0; rd_v[e] = 1'b0; wr_v[e] = 1'b0;
    end
    addr_v[d] = a; wdata_v[d] = w; rd_v[d] = rd; wr_v[d] = wr;
    if (wr) $display("t=%0t dut%0d store addr=%h data=%h", $time, d, a, w);
  endtask

  task automatic wr(input int d, input logic [4:0] off, input logic [31:0] data);
    cyc(d, 1'b0, 1'b1, BASE + {27'h0, off}, data);
  endtask

  task automatic idle(input int d);
    cyc(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd_chk(input int d, input logic [4:0] off, input logic [31:0] exp, input string name);
    cyc(d, 1'b1, 1'b0, BASE + {27'h0, off}, 32'h0);
    #3;
    $display("t=%0t dut%0d load  addr=%h data=%h", $time, d, addr_v[d], rdata_v[d]);
    chk(name, d, rdata_v[d], exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 2; e++) begin
      addr_v[e] = 32'h0; wdata_v[e] = 32'h0; rd_v[e] = 1'b0; wr_v[e] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    $display("t=%0t reset released", $time);
  endtask

  logic [31:0] exp5 [9];

  initial begin
    sw = 8'hA5;
    exp5 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
    for (int e = 0; e < 2; e++) begin
      addr_v[e] = 32'h0; wdata_v[e] = 32'h0; rd_v[e] = 1'b0; wr_v[e] = 1'b0;
    end

    // Reset state and register map
    do_reset();
    #3;
    chk("systick_rst", 0, systick_v[0], 32'd0);
    chk("irq_rst", 0, irq_v[0], 32'd0);
    rd_chk(0, 5'h00, 32'h0, "th_rst");
    chk("systick_1", 0, systick_v[0], 32'd1);
    rd_chk(0, 5'h04, 32'h0, "tl_rst");
    rd_chk(0, 5'h08, 32'h0, "tcon_rst");
    rd_chk(0, 5'h0C, 32'h0, "led_rst");
    rd_chk(0, 5'h10, 32'hA5, "sw_a5");
    rd_chk(0, 5'h14, 32'hFFF, "digi_rst");
    rd_chk(0, 5'h1C, 32'h0, "rsvd_rst");
    sw = 8'h3C;
    rd_chk(0, 5'h10, 32'h3C, "sw_3c");
    wr(0, 5'h0C, 32'h0000_01A5);
    wr(0, 5'h14, 32'hFFFF_F123);
    rd_chk(0, 5'h0C, 32'hA5, "led_wr");
    rd_chk(0, 5'h14, 32'h123, "digi_wr");
    chk("led_pin", 0, led_v[0], 32'hA5);
    wr(0, 5'h18, 32'h0);
    wr(0, 5'h1C, 32'hFFFF_FFFF);
    rd_chk(0, 5'h1C, 32'h0, "rsvd_wr");

    // Overflow with irq enabled
    wr(0, 5'h00, 32'hFFFF_FFFC);
    wr(0, 5'h04, 32'hFFFF_FFFE);
    wr(0, 5'h08, 32'h3);
    idle(0); #3;
    chk("irq_e0", 0, irq_v[0], 32'd0);
    rd_chk(0, 5'h04, 32'hFFFF_FFFF, "tl_e1");
    chk("irq_e1", 0, irq_v[0], 32'd0);
    rd_chk(0, 5'h04, 32'hFFFF_FFFC, "tl_reload");
    chk("irq_rise", 0, irq_v[0], 32'd1);
    rd_chk(0, 5'h04, 32'hFFFF_FFFD, "tl_fd");
    wr(0, 5'h08, 32'h3);
    idle(0); #3;
    chk("irq_clear", 0, irq_v[0], 32'd0);
    wr(0, 5'h08, 32'h0);
    rd_chk(0, 5'h08, 32'h0, "tcon_off");

    // Overflow with irq disabled
    wr(0, 5'h00, 32'hFFFF_FFFC);
    wr(0, 5'h04, 32'hFFFF_FFFE);
    wr(0, 5'h08, 32'h1);
    idle(0);
    idle(0);
    rd_chk(0, 5'h04, 32'hFFFF_FFFC, "tl_reload_noie");
    chk("irq_noie", 0, irq_v[0], 32'd0);
    rd_chk(0, 5'h08, 32'h1, "tcon_noie");
    wr(0, 5'h08, 32'h0);

    // TCON write colliding with overflow
    wr(0, 5'h00, 32'h0);
    wr(0, 5'h04, 32'hFFFF_FFFE);
    wr(0, 5'h08, 32'h3);
    idle(0);
    wr(0, 5'h08, 32'h3);
    rd_chk(0, 5'h08, 32'h7, "tcon_coll");
    chk("irq_coll", 0, irq_v[0], 32'd1);
    wr(0, 5'h08, 32'h0);
    rd_chk(0, 5'h08, 32'h0, "tcon_clr");

    // TL write colliding with overflow
    wr(0, 5'h00, 32'h1234);
    wr(0, 5'h04, 32'hFFFF_FFFE);
    wr(0, 5'h08, 32'h1);
    idle(0);
    wr(0, 5'h04, 32'h5);
    rd_chk(0, 5'h04, 32'h5, "tl_coll");
    rd_chk(0, 5'h04, 32'h6, "tl_coll_next");
    wr(0, 5'h08, 32'h0);
    rd_chk(0, 5'h08, 32'h0, "tcon_tlcoll");

    // TH write colliding with overflow reloads the old TH
    wr(0, 5'h00, 32'h100);
    wr(0, 5'h04, 32'hFFFF_FFFE);
    wr(0, 5'h08, 32'h1);
    idle(0);
    wr(0, 5'h00, 32'h200);
    rd_chk(0, 5'h04, 32'h100, "tl_old_th");
    rd_chk(0, 5'h00, 32'h200, "th_new");
    wr(0, 5'h08, 32'h0);

    // Prescaler of 4 and freeze
    wr(1, 5'h04, 32'h0);
    wr(1, 5'h08, 32'h1);
    for (int i = 0; i < 9; i++) rd_chk(1, 5'h04, exp5[i], "tl_ps4");
    wr(1, 5'h08, 32'h0);
    idle(1);
    idle(1);
    idle(1);
    rd_chk(1, 5'h04, 32'd2, "tl_frozen");
    wr(1, 5'h08, 32'h1);
    rd_chk(1, 5'h04, 32'd2, "tl_resume0");
    rd_chk(1, 5'h04, 32'd2, "tl_resume1");
    rd_chk(1, 5'h04, 32'd3, "tl_resume2");
    wr(1, 5'h08, 32'h0);

    // Out-of-window and misaligned accesses
    wr(0, 5'h00, 32'h11);
    wr(0, 5'h04, 32'h22);
    cyc(0, 1'b0, 1'b1, BASE + 32'h20, 32'hFF); #3;
    chk("hit_20", 0, hit_v[0], 32'd0);
    cyc(0, 1'b0, 1'b1, BASE + 32'h05, 32'hFF); #3;
    chk("hit_05", 0, hit_v[0], 32'd0);
    cyc(0, 1'b1, 1'b0, BASE + 32'h05, 32'h0); #3;
    chk("rdata_05", 0, rdata_v[0], 32'h0);
    rd_chk(0, 5'h00, 32'h11, "th_kept");
    rd_chk(0, 5'h04, 32'h22, "tl_kept");

    // Reset while irq is pending
    wr(0, 5'h00, 32'h0);
    wr(0, 5'h04, 32'hFFFF_FFFF);
    wr(0, 5'h08, 32'h3);
    idle(0);
    idle(0); #3;
    chk("irq_pre_rst", 0, irq_v[0], 32'd1);
    do_reset();
    #3;
    chk("irq_post_rst", 0, irq_v[0], 32'd0);
    rd_chk(0, 5'h04, 32'h0, "tl_post_rst");

    idle(0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
